uart_tx_arbiter: RTL

- Shares one UartTx serializer among NUM_PORTS byte-stream requesters using round-robin arbitration.
- Supports packet-atomic locking: a requester holds the transmitter until it sends a byte flagged last.
- Sequences the UartTx enable/data/ready handshake so no byte is dropped or overlapped.
- Sits between on-board debug/console sources and the single FTDI serial line.

---
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UartTx serializer among NUM_PORTS byte streams.
// A port keeps the transmitter until it sends a byte flagged last. A stalled lock can be dropped after a timeout.
module uart_tx_arbiter #(
    parameter int          NUM_PORTS    = 4,
    parameter logic [31:0] LOCK_TIMEOUT = 32'd1000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         req_valid,
    input  logic [8*NUM_PORTS-1:0]       req_data,
    input  logic [NUM_PORTS-1:0]         req_last,
    output logic [NUM_PORTS-1:0]         req_ready,
    output logic                         tx_enable,
    output logic [7:0]                   tx_data,
    input  logic                         tx_ready,
    output logic [$clog2(NUM_PORTS)-1:0] grant,
    output logic                         locked,
    output logic                         busy
);

    localparam int GW = $clog2(NUM_PORTS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    logic [1:0]    state;
    logic [GW-1:0] rr_ptr;
    logic [31:0]   to_cnt;
    logic [GW-1:0] rr_sel;
    logic [GW-1:0] cand;
    logic [GW-1:0] sel;
    logic          idle;
    logic          xfer;
    logic [7:0]    sel_byte;

    // Scan from the farthest offset to the nearest so the port closest after rr_ptr wins.
    always_comb begin
        rr_sel = rr_ptr;
        cand   = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = GW'((int'(rr_ptr) + k) % NUM_PORTS);
            if (req_valid[cand]) begin
                rr_sel = cand;
            end
        end
    end

    assign idle     = (state == S_IDLE);
    assign sel      = locked ? grant : rr_sel;
    assign xfer     = idle && tx_ready && req_valid[sel];
    assign sel_byte = req_data[{sel, 3'b000} +: 8];
    assign busy     = !idle;

    // A lock owner sees ready even without valid, so it can resume its packet at once.
    always_comb begin
        req_ready = '0;
        if (idle && tx_ready && (locked || req_valid[sel])) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            tx_enable <= 1'b0;
            tx_data   <= 8'h00;
            locked    <= 1'b0;
            grant     <= '0;
            rr_ptr    <= GW'(NUM_PORTS - 1);
            to_cnt    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        tx_data   <= sel_byte;
                        tx_enable <= 1'b1;
                        grant     <= sel;
                        rr_ptr    <= sel;
                        locked    <= !req_last[sel];
                        state     <= S_START;
                    end
                end
                // UartTx loads its bit counter on this edge, so tx_ready is not yet meaningful.
                S_START: begin
                    tx_enable <= 1'b0;
                    state     <= S_BUSY;
                end
                S_BUSY: begin
                    if (tx_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (xfer || !locked) begin
                to_cnt <= 32'd0;
            end else if (idle && !req_valid[grant] && (LOCK_TIMEOUT != 32'd0)) begin
                if (to_cnt == LOCK_TIMEOUT - 32'd1) begin
                    locked <= 1'b0;
                    to_cnt <= 32'd0;
                    rr_ptr <= grant;
                end else begin
                    to_cnt <= to_cnt + 32'd1;
                end
            end
        end
    end

endmodule
